char_lcd_printer: RTL and testbench
===================================

# char_lcd_printer

Downstream consumer of the 64-character display buffer. Takes the flattened 512-bit character frame, snapshots it, and streams it to a 16x4 HD44780-compatible character LCD over a 4-bit write-only bus. It runs the power-on init sequence once, then refreshes all four rows continuously. It pulses `print_fin` after every completed frame so the buffer side can advance or scroll.

## Interface
- `E_PULSE`, default 50: `lcd_e` high time, in clk cycles.
- `NIB_GAP`, default 100: idle cycles between the high and low nibble of one byte.
- `CMD_WAIT`, default 4000: idle cycles after each byte, except clear.
- `CLR_WAIT`, default 200000: idle cycles after the clear-display command (0x01).
- `INIT_WAIT`, default 2000000: power-on wait after reset release, before the first nibble.
- `clk`, input, 1: clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `din`, input, 512: character frame. Char i (0..63) is `din[(64-i)*8-1 -: 8]`, so char 0 is the MSB byte.
- `lcd_rs`, output, 1: 0 = command, 1 = data.
- `lcd_rw`, output, 1: constant 0.
- `lcd_e`, output, 1: enable strobe.
- `lcd_db`, output, 4: data nibble, LCD D7..D4.
- `print_fin`, output, 1: one-cycle pulse at the end of each frame.
- `init_done`, output, 1: high once the init sequence is complete; stays high until reset.

## Operation
- Reset values: all outputs 0; state = PWR_WAIT; wait counter 0.
- PWR_WAIT: count INIT_WAIT cycles, then go to INIT.
- INIT, nibble-only phase: send 0x3, 0x3, 0x3, 0x2 as single nibbles with `lcd_rs`=0. Each is followed by a CMD_WAIT idle.
- INIT, byte phase: send 0x28, 0x0C, 0x06, 0x01 as command bytes. The wait after 0x01 is CLR_WAIT. Then set `init_done` and go to FRAME_START.
- FRAME_START: latch `din` into a 512-bit snapshot; row := 0.
- SET_ADDR: send command 0x80 | ROW_ADDR[row]. ROW_ADDR = {0x00, 0x40, 0x10, 0x50}.
- WRITE_ROW: send 16 data bytes, chars row*16 .. row*16+15 of the snapshot, with `lcd_rs`=1.
- After row 3: `print_fin`=1 for exactly one cycle, then return to FRAME_START. Clear is never resent.
- Byte transfer order: high nibble, NIB_GAP idle, low nibble, then the post-byte wait.
- Snapshot rule: `din` changes mid-frame have no effect until the next FRAME_START. No tearing within a frame.
- Char and column indices are 6-bit and 4-bit counters. The column counter wraps 15→0 while the row counter increments; row 3→0 ends the frame.

## Timing
- Nibble strobe, cycle-exact:
  - cycle 0: `lcd_db`/`lcd_rs` driven, `lcd_e`=0 (setup).
  - cycles 1..E_PULSE: `lcd_e`=1.
  - cycle E_PULSE+1: `lcd_e`=0, data held (hold).
  - Idle begins the cycle after.
- `lcd_db`/`lcd_rs` change only in setup cycles; they hold their value during idle.
- Byte time = 2*(E_PULSE+2) + NIB_GAP + wait, where wait is CMD_WAIT or CLR_WAIT.
- Frame time = 4 * (SET_ADDR byte + 16 data bytes) plus one FRAME_START cycle.
- `print_fin` asserts the cycle after the last CMD_WAIT of row 3 completes. It coincides with FRAME_START.
- Reset mid-transfer:
  - outputs go to 0 asynchronously; `init_done` clears;
  - the full init sequence repeats after release;
  - a partial byte is never completed.

## Structure
- Shared package `lcd_pkg`:
  - command constants: FUNC_SET 0x28, DISP_ON 0x0C, ENTRY 0x06, CLEAR 0x01, SET_DDRAM 0x80;
  - ROW_ADDR table;
  - state enum;
  - default timing constants.
- Sub-module `lcd_nibble_tx`:
  - inputs: `start`, `nib`, `rs`, `gap` (cycle count);
  - outputs: `lcd_e`, `lcd_db`, `lcd_rs`, `done`;
  - owns the E_PULSE timing and the trailing idle counter.
- The top module holds the sequencer FSM, the snapshot register, the row/column counters and the byte→nibble split.

## Test plan
All scenarios use E_PULSE=2, NIB_GAP=3, CMD_WAIT=5, CLR_WAIT=20, INIT_WAIT=10.
- Release reset, watch the bus: no `lcd_e` edge for 10 cycles; first nibble 0x3 with `lcd_rs`=0; nibbles 3,3,3,2 then bytes 28,0C,06,01; 20-cycle idle after 01; `init_done`=1.
- `din` = "Have a fun!" followed by 0x20 padding: row 0 sends 0x80 then 48,61,76,65,20,61,20,66,75,6E,21,20×5. Rows 1–3 send 0xC0/0x90/0xD0 then sixteen 0x20.
- One frame: exactly one `print_fin` pulse per 4×17 bytes. The next frame starts with 0x80 and no 0x01 is resent.
- Change `din` char 0 to 0x41 during row 2: the current frame is unaffected; the next frame's first data byte is 0x41.
- Measure strobes: `lcd_e` high exactly 2 cycles; `lcd_db` stable from one cycle before the rising edge to one cycle after the falling edge.
- Assert `rst` mid data byte: all outputs 0 immediately; after release, the 10-cycle wait and the full init sequence repeat.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared HD44780 command bytes, row addresses, sequencer states and default timing.
package lcd_pkg;
  typedef enum logic [2:0] {PWR_WAIT, INIT_NIB, INIT_BYTE, FRAME_START, SET_ADDR, WRITE_ROW} state_e;
  localparam logic [7:0] FUNC_SET  = 8'h28;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] ENTRY     = 8'h06;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] SET_DDRAM = 8'h80;
  localparam logic [7:0] ROW_ADDR  [4] = '{8'h00, 8'h40, 8'h10, 8'h50};
  localparam logic [7:0] INIT_NIBS [4] = '{8'h03, 8'h03, 8'h03, 8'h02};
  localparam logic [7:0] INIT_CMDS [4] = '{FUNC_SET, DISP_ON, ENTRY, CLEAR};
  localparam int DEF_E_PULSE   = 50;
  localparam int DEF_NIB_GAP   = 100;
  localparam int DEF_CMD_WAIT  = 4000;
  localparam int DEF_CLR_WAIT  = 200000;
  localparam int DEF_INIT_WAIT = 2000000;
endpackage

// File: rtl/char_lcd_printer_if.sv
// char_lcd_printer_if: 4-bit HD44780 write bus plus frame/init status.
interface char_lcd_printer_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [3:0] lcd_db;
  logic       print_fin;
  logic       init_done;
  modport master (output lcd_rs, lcd_rw, lcd_e, lcd_db, print_fin, init_done);
  modport slave  (input lcd_rs, lcd_rw, lcd_e, lcd_db, print_fin, init_done);
endinterface

// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: one nibble strobe (setup, E_PULSE high, hold) followed by gap idle cycles.
module lcd_nibble_tx import lcd_pkg::*; #(
  parameter int E_PULSE = DEF_E_PULSE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  nib,
  input  logic        rs,
  input  logic [31:0] gap,
  output logic        lcd_e,
  output logic [3:0]  lcd_db,
  output logic        lcd_rs,
  output logic        done
);
  logic        busy_q, busy_d, e_q, e_d, rs_q, rs_d;
  logic [3:0]  db_q, db_d;
  logic [31:0] cnt_q, cnt_d, gap_q, gap_d;
  // done marks the last idle cycle so a following start lands its setup cycle back-to-back
  always_comb begin
    done   = busy_q && cnt_q == 32'(E_PULSE + 1) + gap_q;
    busy_d = start || (busy_q && !done);
    cnt_d  = start ? 32'd0 : busy_q ? cnt_q + 32'd1 : cnt_q;
    db_d   = start ? nib : db_q;
    rs_d   = start ? rs : rs_q;
    gap_d  = start ? gap : gap_q;
    e_d    = busy_d && cnt_d >= 32'd1 && cnt_d <= 32'(E_PULSE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      e_q    <= 1'b0;
      rs_q   <= 1'b0;
      db_q   <= '0;
      cnt_q  <= '0;
      gap_q  <= '0;
    end else begin
      busy_q <= busy_d;
      e_q    <= e_d;
      rs_q   <= rs_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      gap_q  <= gap_d;
    end
  end
  assign lcd_e  = e_q;
  assign lcd_db = db_q;
  assign lcd_rs = rs_q;
endmodule

// File: rtl/char_lcd_printer.sv
// char_lcd_printer: runs HD44780 init once, then streams 4 rows of a snapshotted 64-char frame forever.
module char_lcd_printer import lcd_pkg::*; #(
  parameter int E_PULSE   = DEF_E_PULSE,
  parameter int NIB_GAP   = DEF_NIB_GAP,
  parameter int CMD_WAIT  = DEF_CMD_WAIT,
  parameter int CLR_WAIT  = DEF_CLR_WAIT,
  parameter int INIT_WAIT = DEF_INIT_WAIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] din,
  char_lcd_printer_if.master lcd
);
  state_e       state_q, state_d;
  logic [31:0]  wait_q, wait_d;
  logic [1:0]   idx_q, idx_d, row_q, row_d;
  logic [3:0]   col_q, col_d;
  logic         lo_q, lo_d, init_done_q, init_done_d, print_fin_q, print_fin_d;
  logic [511:0] snap_q, snap_d;
  logic         start, rs, done;
  logic [3:0]   nib;
  logic [31:0]  gap;
  logic [8:0]   base;
  logic [7:0]   chr, byte_d;
  // lo_q flags that the nibble in flight is the low (final) one of its byte
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    idx_d       = idx_q;
    row_d       = row_q;
    col_d       = col_q;
    lo_d        = lo_q;
    snap_d      = snap_q;
    init_done_d = init_done_q;
    print_fin_d = 1'b0;
    start       = 1'b0;
    case (state_q)
      PWR_WAIT: begin
        wait_d = wait_q + 32'd1;
        if (wait_q == 32'(INIT_WAIT - 1)) begin
          state_d = INIT_NIB;
          idx_d   = '0;
          lo_d    = 1'b1;
          start   = 1'b1;
        end
      end
      INIT_NIB: if (done) begin
        start = 1'b1;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = INIT_BYTE;
          lo_d    = 1'b0;
        end
      end
      INIT_BYTE: if (done) begin
        lo_d = !lo_q;
        if (!lo_q) start = 1'b1;
        else if (idx_q == 2'd3) begin
          state_d     = FRAME_START;
          init_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 2'd1;
          start = 1'b1;
        end
      end
      FRAME_START: begin
        snap_d  = din;
        row_d   = '0;
        col_d   = '0;
        lo_d    = 1'b0;
        state_d = SET_ADDR;
        start   = 1'b1;
      end
      SET_ADDR: if (done) begin
        lo_d  = !lo_q;
        start = 1'b1;
        if (lo_q) state_d = WRITE_ROW;
      end
      WRITE_ROW: if (done) begin
        lo_d = !lo_q;
        if (!lo_q) start = 1'b1;
        else begin
          col_d = col_q + 4'd1;
          if (col_q != 4'd15) start = 1'b1;
          else if (row_q == 2'd3) begin
            state_d     = FRAME_START;
            print_fin_d = 1'b1;
          end else begin
            row_d   = row_q + 2'd1;
            state_d = SET_ADDR;
            start   = 1'b1;
          end
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end
  // the nibble to launch is chosen from next-state values so it is ready the cycle start fires
  always_comb begin
    base   = 9'd511 - {row_d, col_d, 3'b000};
    chr    = snap_q[base -: 8];
    byte_d = state_d == INIT_NIB  ? INIT_NIBS[idx_d] :
             state_d == INIT_BYTE ? INIT_CMDS[idx_d] :
             state_d == SET_ADDR  ? (SET_DDRAM | ROW_ADDR[row_d]) : chr;
    nib    = lo_d ? byte_d[3:0] : byte_d[7:4];
    rs     = state_d == WRITE_ROW;
    gap    = !lo_d ? 32'(NIB_GAP) :
             (state_d == INIT_BYTE && byte_d == CLEAR) ? 32'(CLR_WAIT) : 32'(CMD_WAIT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PWR_WAIT;
      wait_q      <= '0;
      idx_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      lo_q        <= 1'b0;
      snap_q      <= '0;
      init_done_q <= 1'b0;
      print_fin_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      lo_q        <= lo_d;
      snap_q      <= snap_d;
      init_done_q <= init_done_d;
      print_fin_q <= print_fin_d;
    end
  end
  lcd_nibble_tx #(.E_PULSE(E_PULSE)) u_tx (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .nib    (nib),
    .rs     (rs),
    .gap    (gap),
    .lcd_e  (lcd.lcd_e),
    .lcd_db (lcd.lcd_db),
    .lcd_rs (lcd.lcd_rs),
    .done   (done)
  );
  assign lcd.lcd_rw    = 1'b0;
  assign lcd.init_done = init_done_q;
  assign lcd.print_fin = print_fin_q;
endmodule

// File: tb/tb_char_lcd_printer.sv
// tb_char_lcd_printer: scoreboard of expected nibbles built from frame contents, checked by a bus monitor.
module tb_char_lcd_printer;
  localparam int E = 2, G = 3, CW = 5, CLR = 20, IW = 10;
  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         delta;
    logic       dn;
    int         fins;
  } exp_t;

  logic         clk = 1'b0, rst = 1'b1;
  logic [511:0] din = '0;
  char_lcd_printer_if bus();
  char_lcd_printer #(.E_PULSE(E), .NIB_GAP(G), .CMD_WAIT(CW), .CLR_WAIT(CLR), .INIT_WAIT(IW)) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .lcd (bus)
  );
  always #5 clk = ~clk;

  int compared = 0, failed = 0;
  int cyc = 0;
  exp_t q[$];
  int pend_gap = 0;
  bit first = 1'b1;
  logic [7:0] ra [4] = '{8'h00, 8'h40, 8'h10, 8'h50};

  always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

  function automatic void chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endfunction

  // expected rise-to-rise spacing: previous nibble's strobe + its idle, plus one FRAME_START cycle when asked
  function automatic void push_nib(logic rs, logic [3:0] nib, int gap, int extra, logic dn, int fins);
    exp_t e;
    e.rs = rs; e.nib = nib; e.dn = dn; e.fins = fins;
    e.delta = first ? -1 : E + 2 + pend_gap + extra;
    first = 1'b0;
    pend_gap = gap;
    q.push_back(e);
  endfunction

  function automatic void push_byte(logic rs, logic [7:0] b, int wt, int extra, logic dn, int fins);
    push_nib(rs, b[7:4], G, extra, dn, fins);
    push_nib(rs, b[3:0], wt, 0, dn, fins);
  endfunction

  function automatic void push_init();
    first = 1'b1;
    push_nib(1'b0, 4'h3, CW, 0, 1'b0, 0);
    push_nib(1'b0, 4'h3, CW, 0, 1'b0, 0);
    push_nib(1'b0, 4'h3, CW, 0, 1'b0, 0);
    push_nib(1'b0, 4'h2, CW, 0, 1'b0, 0);
    push_byte(1'b0, 8'h28, CW, 0, 1'b0, 0);
    push_byte(1'b0, 8'h0C, CW, 0, 1'b0, 0);
    push_byte(1'b0, 8'h06, CW, 0, 1'b0, 0);
    push_byte(1'b0, 8'h01, CLR, 0, 1'b0, 0);
  endfunction

  function automatic void push_frame(logic [511:0] d, int k);
    for (int r = 0; r < 4; r++) begin
      push_byte(1'b0, 8'h80 | ra[r], CW, (r == 0) ? 1 : 0, 1'b1, k);
      for (int c = 0; c < 16; c++)
        push_byte(1'b1, 8'(d >> ((63 - (r * 16 + c)) * 8)), CW, 0, 1'b1, k);
    end
  endfunction

  function automatic logic [511:0] rnd_frame();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [511:0] msg_frame();
    logic [511:0] d;
    string s = "Have a fun!";
    for (int i = 0; i < 64; i++) d[(64 - i) * 8 - 1 -: 8] = (i < s.len()) ? s[i] : 8'h20;
    return d;
  endfunction

  // bus monitor
  logic       prev_e = 1'b0, prev_rs = 1'b0, prev_fin = 1'b0, s_rs = 1'b0, stable = 1'b0, r_done = 1'b0;
  logic [3:0] prev_db = '0, s_db = '0;
  int         rise_cyc = 0, last_rise = 0, fin_seen = 0, nib_seen = 0, r_fins = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_e = 1'b0; prev_fin = 1'b0; fin_seen = 0; nib_seen = 0;
    end else begin
      if (bus.print_fin) begin
        chk("fin_one_cycle", int'(prev_fin), 0);
        fin_seen++;
      end
      if (bus.lcd_e && !prev_e) begin
        rise_cyc = cyc; s_db = prev_db; s_rs = prev_rs;
        stable = (bus.lcd_db == prev_db) && (bus.lcd_rs == prev_rs);
        r_done = bus.init_done; r_fins = fin_seen;
      end else if (prev_e) stable = stable && bus.lcd_db == s_db && bus.lcd_rs == s_rs;
      if (!bus.lcd_e && prev_e) begin
        if (q.size() == 0) chk("unexpected_nibble", int'({s_rs, s_db}), -1);
        else begin
          exp_t x;
          x = q.pop_front();
          chk("rs_nibble", int'({s_rs, s_db}), int'({x.rs, x.nib}));
          if (x.delta < 0) chk("pwr_wait_first_rise", int'(rise_cyc > IW && rise_cyc <= IW + 3), 1);
          else chk("nibble_spacing", rise_cyc - last_rise, x.delta);
          chk("e_width", cyc - rise_cyc, E);
          chk("db_stable", int'(stable), 1);
          chk("init_done", int'(r_done), int'(x.dn));
          chk("fin_count", r_fins, x.fins);
        end
        last_rise = rise_cyc;
        nib_seen++;
      end
      prev_e = bus.lcd_e; prev_db = bus.lcd_db; prev_rs = bus.lcd_rs; prev_fin = bus.print_fin;
    end
  end

  task automatic wait_nib(int n);
    int t = 0;
    while (nib_seen < n && t < 20000) begin
      @(negedge clk); #1;
      t++;
    end
    if (nib_seen < n) chk("wait_nibbles_timeout", nib_seen, n);
  endtask

  initial begin
    logic [511:0] nxt;
    int t;
    din = msg_frame();
    push_init();
    push_frame(din, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_nib(12 + 136 * k + 37);
      din = rnd_frame();
      wait_nib(12 + 136 * k + 68);
      nxt = rnd_frame();
      if (k == 0) begin
        nxt = msg_frame();
        nxt[511:504] = 8'h41;
      end
      din = nxt;
      push_frame(nxt, k + 1);
    end
    wait_nib(12 + 136 * 4 + 5);
    t = 0;
    while (!bus.lcd_e && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("e_high_before_reset", int'(bus.lcd_e), 1);
    chk("init_done_before_reset", int'(bus.init_done), 1);
    #2 rst = 1'b1;
    #1 chk("rst_outputs_async", int'({bus.lcd_e, bus.lcd_db, bus.lcd_rs, bus.lcd_rw, bus.print_fin, bus.init_done}), 0);
    q.delete();
    repeat (3) @(negedge clk);
    chk("rst_outputs_held", int'({bus.lcd_e, bus.lcd_db, bus.lcd_rs, bus.lcd_rw, bus.print_fin, bus.init_done}), 0);
    din = rnd_frame();
    push_init();
    push_frame(din, 0);
    rst = 1'b0;
    wait_nib(12 + 136);
    chk("queue_drained", q.size(), 0);
    repeat (7) @(negedge clk);
    chk("fin_after_frame", fin_seen, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
